data_in32: RTL and testbench

//  Word-serial input assembler: collects WORDS consecutive WIDTH-bit words from a
//  32-bit bus into one WORDS*WIDTH-bit block (default 8x32 = 256 bits) for the core datapath.
//  It is the write-side counterpart of the 256->8x32 output register. The block

---
 rtl/data_in32.sv | 80 ++++++++
 tb/tb_data_in32.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/data_in32.sv
// Word-serial input assembler: gathers WORDS words from DI into one wide block on PDO,
// then holds that block until the core acknowledges it with PDO_ACK.
module data_in32 #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned WORDS   = 8,
    parameter logic [2:0]  LOAD_ST = 3'b001
) (
    input  logic                       CLK,
    input  logic                       rst,
    input  logic [2:0]                 st,
    input  logic                       CLR,
    input  logic [WIDTH-1:0]           DI,
    input  logic                       DI_VALID,
    output logic                       DI_READY,
    output logic [WIDTH*WORDS-1:0]     PDO,
    output logic                       PDO_VALID,
    input  logic                       PDO_ACK,
    output logic [$clog2(WORDS):0]     CNT
);

    localparam int unsigned IW = $clog2(WORDS);
    localparam int unsigned CW = IW + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFull
    } state_e;

    state_e        state_q;
    logic          accept;
    logic [IW-1:0] widx;

    assign DI_READY = (state_q != StFull) && (st == LOAD_ST);
    assign accept   = DI_VALID && DI_READY && !CLR;
    assign widx     = CNT[IW-1:0];

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= StIdle;
            CNT       <= '0;
            PDO       <= '0;
            PDO_VALID <= 1'b0;
        end else if (CLR) begin
            // Flush only; PDO contents are simply overwritten by the next block.
            state_q   <= StIdle;
            CNT       <= '0;
            PDO_VALID <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StFill: begin
                    if (accept) begin
                        PDO[widx*WIDTH +: WIDTH] <= DI;
                        CNT                      <= CNT + CW'(1);
                        if (CNT == LAST_IDX) begin
                            state_q   <= StFull;
                            PDO_VALID <= 1'b1;
                        end else begin
                            state_q <= StFill;
                        end
                    end
                end
                StFull: begin
                    if (PDO_ACK) begin
                        state_q   <= StIdle;
                        CNT       <= '0;
                        PDO_VALID <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    CNT       <= '0;
                    PDO_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_in32.sv
// Self-checking bench for data_in32: vector table, directed corner sequences and random
// traffic, all compared against a word-array model of the block assembler.
module tb_data_in32;

    localparam logic [2:0] LOAD = 3'b001;

    logic         CLK = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   st = 3'b000;
    logic         CLR = 1'b0;
    logic [31:0]  DI = '0;
    logic         DI_VALID = 1'b0;
    logic         DI_READY;
    logic [255:0] PDO;
    logic         PDO_VALID;
    logic         PDO_ACK = 1'b0;
    logic [3:0]   CNT;

    int checks = 0;
    int failures = 0;

    // Model: the block is an array of words plus a fill count and a "block complete" flag.
    logic [31:0] m_w[8];
    int          m_cnt = 0;
    bit          m_full = 1'b0;

    data_in32 dut (
        .CLK      (CLK),
        .rst      (rst),
        .st       (st),
        .CLR      (CLR),
        .DI       (DI),
        .DI_VALID (DI_VALID),
        .DI_READY (DI_READY),
        .PDO      (PDO),
        .PDO_VALID(PDO_VALID),
        .PDO_ACK  (PDO_ACK),
        .CNT      (CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          r;
        logic [2:0]  s;
        bit          c;
        logic [31:0] d;
        bit          v;
        bit          a;
        bit          exp_ready;
        int          exp_cnt;
        bit          exp_valid;
    } vec_t;

    function automatic logic [255:0] model_block();
        logic [255:0] b;
        for (int k = 0; k < 8; k++) b[k*32 +: 32] = m_w[k];
        return b;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input logic [2:0] s, input bit c, input logic [31:0] d,
                              input bit v, input bit a);
        if (r) begin
            m_cnt = 0;
            m_full = 1'b0;
            for (int k = 0; k < 8; k++) m_w[k] = '0;
        end else if (c) begin
            m_cnt = 0;
            m_full = 1'b0;
        end else if (m_full) begin
            if (a) begin
                m_full = 1'b0;
                m_cnt = 0;
            end
        end else if (v && s == LOAD) begin
            m_w[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 8) m_full = 1'b1;
        end
    endtask

    // One clock: drive at negedge, check DI_READY, then check registered outputs after the edge.
    task automatic cyc(input bit r, input logic [2:0] s, input bit c, input logic [31:0] d,
                       input bit v, input bit a);
        @(negedge CLK);
        rst = r; st = s; CLR = c; DI = d; DI_VALID = v; PDO_ACK = a;
        #1;
        chk("DI_READY", {255'b0, DI_READY}, {255'b0, (!m_full && s == LOAD)});
        @(posedge CLK);
        model_step(r, s, c, d, v, a);
        #1;
        chk("CNT", {252'b0, CNT}, 256'(m_cnt));
        chk("PDO_VALID", {255'b0, PDO_VALID}, {255'b0, m_full});
        chk("PDO", PDO, model_block());
    endtask

    vec_t tbl[$];

    initial begin
        vec_t t;
        for (int k = 0; k < 8; k++) m_w[k] = '0;

        // Table: reset, 8-word load, DI_VALID ignored while full, then acknowledge.
        tbl.push_back('{1, LOAD, 0, 32'h0, 0, 0, 1, 0, 0});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{0, LOAD, 0, 32'(i), 1, 0, 1, i + 1, i == 7});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{0, LOAD, 0, 32'hDEADBEEF, 1, 0, 0, 8, 1});
        tbl.push_back('{0, LOAD, 0, 32'h0, 0, 1, 0, 0, 0});

        cyc(1, LOAD, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            t = tbl[i];
            cyc(t.r, t.s, t.c, t.d, t.v, t.a);
            chk("tbl_cnt", {252'b0, CNT}, 256'(t.exp_cnt));
            chk("tbl_valid", {255'b0, PDO_VALID}, {255'b0, t.exp_valid});
            if (i == 8) begin
                chk("tbl_word0", {224'b0, PDO[31:0]}, 256'h0);
                chk("tbl_word7", {224'b0, PDO[255:224]}, 256'h7);
            end
        end

        // Stall: 3 words, st off-LOAD for 4 cycles, then 5 more words.
        for (int i = 0; i < 3; i++) cyc(0, LOAD, 0, 32'hA0 + 32'(i), 1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 3'b101, 0, 32'hEE, 1, 0);
            chk("stall_cnt", {252'b0, CNT}, 256'd3);
        end
        cyc(0, LOAD, 0, 0, 0, 1);  // ack outside FULL has no effect
        for (int i = 0; i < 5; i++) cyc(0, LOAD, 0, 32'hB0 + 32'(i), 1, 0);
        chk("stall_w2", {224'b0, PDO[95:64]}, 256'hA2);
        chk("stall_w3", {224'b0, PDO[127:96]}, 256'hB0);
        chk("stall_valid", {255'b0, PDO_VALID}, 256'd1);
        cyc(0, LOAD, 0, 0, 0, 1);

        // CLR after 5 words discards the word presented with it.
        for (int i = 0; i < 5; i++) cyc(0, LOAD, 0, 32'hC0 + 32'(i), 1, 0);
        cyc(0, LOAD, 1, 32'hBAD, 1, 0);
        chk("clr_cnt", {252'b0, CNT}, 256'd0);
        for (int i = 0; i < 8; i++) cyc(0, LOAD, 0, 32'hD0 + 32'(i), 1, 0);
        chk("clr_w0", {224'b0, PDO[31:0]}, 256'hD0);
        chk("clr_w5", {224'b0, PDO[191:160]}, 256'hD5);
        cyc(0, LOAD, 1, 0, 0, 1);  // CLR together with ACK

        // Reset mid-fill zeroes the block, then a fresh load.
        for (int i = 0; i < 6; i++) cyc(0, LOAD, 0, 32'hE0 + 32'(i), 1, 0);
        cyc(1, LOAD, 0, 32'h55, 1, 0);
        chk("rst_pdo", PDO, 256'h0);
        for (int i = 0; i < 8; i++) cyc(0, LOAD, 0, 32'hF0 + 32'(i), 1, 0);
        chk("rst_w7", {224'b0, PDO[255:224]}, 256'hF7);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] s;
            s = ($urandom_range(0, 3) != 0) ? LOAD : 3'($urandom);
            cyc($urandom_range(0, 199) == 0, s, $urandom_range(0, 39) == 0, $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
